// File: rtl/arith_wb_arb_pkg.sv
// Shared types for the arithmetic writeback path: functional-unit result
// payload, starvation counter type and default divider FIFO depth.
package arith_wb_arb_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [7:0]  id;
    logic [5:0]  prd;
    logic [31:0] rdval;
  } fu_output_t;

  typedef logic [7:0] starve_cnt_t;

  localparam int unsigned ARITH_WB_FIFO_DEPTH = 4;

endpackage

// File: rtl/fu_result_fifo.sv
// Small FIFO of functional-unit results. Pointers carry one extra wrap bit
// so full and empty are distinguishable without an occupancy counter.
module fu_result_fifo
  import arith_wb_arb_pkg::*;
#(
  parameter int unsigned DEPTH = ARITH_WB_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enq,
  input  logic       deq,
  input  logic       flush,
  input  fu_output_t din,
  output logic       full,
  output logic       empty,
  output fu_output_t head
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_q, rd_q;
  fu_output_t  mem_q [DEPTH];
  logic        do_enq, do_deq;

  // Flush wins over any push/pop in the same cycle.
  always_comb begin
    do_enq = enq & ~full & ~flush;
    do_deq = deq & ~empty & ~flush;
    empty  = (wr_q == rd_q);
    full   = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    head   = mem_q[rd_q[AW-1:0]];
  end

  // Pointer update; both pointers return to 0 on reset or flush.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_enq) wr_q <= wr_q + 1'b1;
      if (do_deq) rd_q <= rd_q + 1'b1;
    end
  end

  // Storage write; contents need no reset since empty masks them.
  always_ff @(posedge clk) begin
    if (do_enq) mem_q[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/arith_wb_arb.sv
// Writeback arbiter: the multiplier always owns the port; divider results
// queue in a FIFO and drain into idle slots. A starvation counter asks issue
// for a multiplier bubble when the queue head waits too long.
module arith_wb_arb
  import arith_wb_arb_pkg::*;
#(
  parameter int unsigned DEPTH      = ARITH_WB_FIFO_DEPTH,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  fu_output_t mul_i,
  input  logic       mul_i_valid,
  input  fu_output_t div_i,
  input  logic       div_i_valid,
  output logic       div_i_ready,
  output fu_output_t wb_o,
  output logic       wb_o_valid,
  output logic       mul_block_o,
  input  logic       squash
);

  localparam starve_cnt_t StarveMax = starve_cnt_t'(STARVE_MAX);

  logic        full, empty, enq, deq;
  fu_output_t  head;
  starve_cnt_t count_q, count_d;

  fu_result_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .enq   (enq),
    .deq   (deq),
    .flush (squash),
    .din   (div_i),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  // Port selection: multiplier first, FIFO head into idle slots only.
  always_comb begin
    div_i_ready = ~full;
    enq         = div_i_valid & ~full & ~squash;
    deq         = ~squash & ~mul_i_valid & ~empty;
    wb_o_valid  = ~squash & (mul_i_valid | ~empty);
    wb_o        = mul_i_valid ? mul_i : head;
    mul_block_o = (count_q == StarveMax);
  end

  // Starvation count: blocked cycles since the head last drained.
  always_comb begin
    count_d = count_q;
    if (squash || deq) begin
      count_d = '0;
    end else if (!empty && mul_i_valid && count_q != StarveMax) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: tb/tb_arith_wb_arb.sv
// Directed bench for arith_wb_arb with DEPTH=4, STARVE_MAX=8.
module tb_arith_wb_arb;
  import arith_wb_arb_pkg::*;

  localparam int unsigned Depth = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  fu_output_t mul_i, div_i, wb_o;
  logic       mul_i_valid = 1'b0;
  logic       div_i_valid = 1'b0;
  logic       div_i_ready, wb_o_valid, mul_block_o;
  logic       squash = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  arith_wb_arb #(
    .DEPTH      (Depth),
    .STARVE_MAX (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mul_i       (mul_i),
    .mul_i_valid (mul_i_valid),
    .div_i       (div_i),
    .div_i_valid (div_i_valid),
    .div_i_ready (div_i_ready),
    .wb_o        (wb_o),
    .wb_o_valid  (wb_o_valid),
    .mul_block_o (mul_block_o),
    .squash      (squash)
  );

  always #5 clk = ~clk;

  function automatic fu_output_t mk(input int id);
    fu_output_t r;
    r.pc    = 32'(id) << 2;
    r.id    = 8'(id);
    r.prd   = 6'(id);
    r.rdval = 32'(id) * 32'd3 + 32'd1;
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  int q[$];
  int next_in, out_cnt, k;

  initial begin
    mul_i = mk(0);
    div_i = mk(0);
    tick(); tick();
    rst = 1'b0;
    settle();

    // Reset state
    check("rst_ready", 64'(div_i_ready), 64'd1);
    check("rst_wbv",   64'(wb_o_valid),  64'd0);
    check("rst_block", 64'(mul_block_o), 64'd0);

    // Single divider result, idle multiplier: writeback one cycle later
    div_i_valid = 1'b1; div_i = mk(3);
    settle();
    check("t1_ready", 64'(div_i_ready), 64'd1);
    check("t1_nobyp", 64'(wb_o_valid),  64'd0);
    tick();
    div_i_valid = 1'b0;
    settle();
    check("t1_wbv", 64'(wb_o_valid), 64'd1);
    check("t1_id",  64'(wb_o.id),    64'd3);
    check("t1_val", 64'(wb_o.rdval), 64'd10);
    tick();
    check("t1_idle", 64'(wb_o_valid), 64'd0);

    // Starvation: 20 multiplier cycles, one divider result enqueued in cycle 0
    for (int i = 0; i < 20; i++) begin
      mul_i_valid = 1'b1; mul_i = mk(100 + i);
      div_i_valid = (i == 0); div_i = mk(5);
      settle();
      if (i == 0 || i == 19) check("t2_mulid", 64'(wb_o.id), 64'(100 + i));
      if (i == 8)  check("t2_block8", 64'(mul_block_o), 64'd0);
      if (i == 9)  check("t2_block9", 64'(mul_block_o), 64'd1);
      if (i == 19) check("t2_block19", 64'(mul_block_o), 64'd1);
      tick();
    end
    mul_i_valid = 1'b0; div_i_valid = 1'b0;
    settle();
    check("t2_wbv",    64'(wb_o_valid),  64'd1);
    check("t2_id",     64'(wb_o.id),     64'd5);
    check("t2_blk_on", 64'(mul_block_o), 64'd1);
    tick();
    check("t2_blk_off", 64'(mul_block_o), 64'd0);
    check("t2_idle",    64'(wb_o_valid),  64'd0);

    // Five back-to-back divider results under multiplier traffic
    for (int j = 0; j < 5; j++) begin
      mul_i_valid = 1'b1; mul_i = mk(50);
      div_i_valid = 1'b1; div_i = mk(10 + j);
      settle();
      check("t3_ready", 64'(div_i_ready), (j < 4) ? 64'd1 : 64'd0);
      tick();
    end
    mul_i_valid = 1'b0; div_i_valid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      settle();
      check("t3_wbv", 64'(wb_o_valid), 64'd1);
      check("t3_id",  64'(wb_o.id),    64'(10 + j));
      tick();
    end
    check("t3_empty", 64'(wb_o_valid), 64'd0);

    // Squash with 3 queued entries and a live divider input
    for (int j = 0; j < 3; j++) begin
      mul_i_valid = 1'b1; mul_i = mk(60);
      div_i_valid = 1'b1; div_i = mk(20 + j);
      tick();
    end
    squash = 1'b1; div_i = mk(99);
    settle();
    check("t4_sq_wbv",   64'(wb_o_valid),  64'd0);
    check("t4_sq_ready", 64'(div_i_ready), 64'd1);
    tick();
    squash = 1'b0; mul_i_valid = 1'b0; div_i_valid = 1'b0;
    settle();
    check("t4_post_wbv",   64'(wb_o_valid),  64'd0);
    check("t4_post_block", 64'(mul_block_o), 64'd0);
    tick();
    check("t4_post_wbv2", 64'(wb_o_valid), 64'd0);

    // Full FIFO with dequeue and new input in one cycle; ids 0..11 across wrap
    next_in = 0; out_cnt = 0; k = 0;
    q.delete();
    while (out_cnt < 12 && k < 80) begin
      mul_i_valid = (k < 4) ? 1'b1 : ((k % 3) == 0);
      mul_i       = mk(200 + k);
      div_i_valid = (next_in < 12);
      div_i       = mk(next_in);
      settle();
      check("t5_ready", 64'(div_i_ready), (q.size() < Depth) ? 64'd1 : 64'd0);
      check("t5_wbv",   64'(wb_o_valid),  (mul_i_valid || q.size() > 0) ? 64'd1 : 64'd0);
      if (mul_i_valid) begin
        check("t5_mulid", 64'(wb_o.id), 64'(200 + k));
      end else if (q.size() > 0) begin
        check("t5_divid", 64'(wb_o.id), 64'(q[0]));
        check("t5_order", 64'(wb_o.id), 64'(out_cnt));
        void'(q.pop_front());
        out_cnt++;
      end
      if (div_i_valid && div_i_ready) begin
        q.push_back(next_in);
        next_in++;
      end
      tick();
      k++;
    end
    check("t5_drained", 64'(out_cnt), 64'd12);
    mul_i_valid = 1'b0; div_i_valid = 1'b0;
    settle();
    check("t5_idle", 64'(wb_o_valid), 64'd0);

    // Reset mid-operation with 2 entries queued and block asserted
    for (int j = 0; j < 12; j++) begin
      mul_i_valid = 1'b1; mul_i = mk(70);
      div_i_valid = (j < 2); div_i = mk(30 + j);
      tick();
    end
    div_i_valid = 1'b0;
    settle();
    check("t6_pre_block", 64'(mul_block_o), 64'd1);
    rst = 1'b1; mul_i_valid = 1'b0;
    tick();
    rst = 1'b0;
    settle();
    check("t6_block", 64'(mul_block_o), 64'd0);
    check("t6_ready", 64'(div_i_ready), 64'd1);
    check("t6_wbv",   64'(wb_o_valid),  64'd0);
    tick();
    check("t6_wbv2",  64'(wb_o_valid),  64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
